eth_rx_ctrl: RTL and testbench
==============================

ETH_RX_CTRL -- requirements
Module: eth_rx_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, 12, data RAM address width (2^ADDR_W bytes); LEN_AW, 3, length FIFO address width (2^LEN_AW frames).
REQ-002 SHALL have ports:
- clk_mac  in  1  MAC clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- rx_vld, rx_sof, rx_eof, rx_err  in  1 each  upstream receive byte stream.
- rx_dat  in  8  upstream receive byte.
- cfg_mac  in  48  station MAC; byte 0 in [47:40].
- cfg_promisc  in  1  accept all destination addresses.
- out_vld  out  1  output byte valid.
- out_dat  out  8  output byte.
- out_sof, out_eof  out  1 each  first / last byte of frame.
- out_len  out  11  frame length; valid with out_sof.
- out_rdy  in  1  consumer ready.
- frm_cnt, drop_cnt  out  16 each  accepted / dropped frame counters; saturating.

Function
REQ-003 SHALL treat a beat with rx_vld=1 and rx_eof=0 as a data byte; rx_sof=1 marks byte 0.
REQ-004 SHALL treat a beat with rx_vld=1 and rx_eof=1 as end of frame with no data byte; rx_err is sampled only on this beat.
REQ-005 Write FSM states SHALL be W_IDLE, W_DATA and W_DROP.
- W_IDLE→W_DATA on an sof byte; the byte is written.
- W_DATA→W_IDLE on eof.
- W_DATA→W_DROP on a drop condition (REQ-007).
- W_DROP→W_IDLE on eof.
- Non-sof data bytes in W_IDLE SHALL be ignored.
REQ-006 SHALL write each accepted byte to data RAM at wr_ptr and increment wr_ptr modulo 2^ADDR_W. commit_ptr SHALL hold the wr_ptr value at the start of the current frame.
REQ-007 Drop conditions:
- Length FIFO full at sof.
- Data RAM full: wr_ptr+1 == rd_ptr.
- Frame length exceeds 2047 bytes.
- Destination mismatch: bytes 0..5 not equal to cfg_mac, not all 0xFF, and cfg_promisc=0.
REQ-008 On eof SHALL commit iff all hold: no drop condition, rx_err=0, length ≥ 14. Commit SHALL push the length into the FIFO, set commit_ptr=wr_ptr and increment frm_cnt; length is one cycle later visible to the read side.
REQ-009 Otherwise SHALL roll back wr_ptr to commit_ptr and increment drop_cnt once per frame.
REQ-010 An sof byte arriving in W_DATA or W_DROP SHALL abort the current frame: roll back and count one drop, then start the new frame in the same cycle.
REQ-011 Read FSM states SHALL be R_IDLE, R_FETCH and R_DATA.
- R_IDLE→R_FETCH when the length FIFO is non-empty.
- R_FETCH→R_DATA after RAM read latency; out_vld rises no later than 2 cycles after FIFO non-empty.
- R_DATA→R_IDLE after the out_eof byte is accepted; the FIFO pops then.
REQ-012 Output SHALL follow valid/ready:
- out_vld, out_dat, out_sof, out_eof and out_len SHALL stay stable while out_vld=1 and out_rdy=0.
- A byte is accepted when out_vld and out_rdy are both 1; rd_ptr advances per accepted byte.
- Throughput SHALL be sustained one byte per cycle while out_rdy=1.
REQ-013 A frame of length 1 is impossible (minimum 14); out_sof and out_eof SHALL never coincide.
REQ-014 Simultaneous commit and pop SHALL both take effect; FIFO occupancy is unchanged.
REQ-015 Counters SHALL saturate at 0xFFFF.

Reset
REQ-016 While rst=1 SHALL clear wr_ptr, commit_ptr, rd_ptr, FIFO pointers, frm_cnt, drop_cnt, out_vld, out_sof, out_eof, out_dat and out_len to 0, and set FSMs to W_IDLE/R_IDLE.
REQ-017 Reset mid-frame SHALL discard all stored frames without counting drops.

Structure
REQ-018 Package eth_pkg SHALL hold W_*/R_* state encodings, ETH_MIN_LEN=14, ETH_MAX_LEN=2047 and ETH_BCAST=48'hFFFFFFFFFFFF.
REQ-019 SHALL instantiate one sub-module eth_rx_dpram: simple dual-port RAM, 1-cycle registered read. The length FIFO SHALL be inline.

Verification
REQ-020 64-byte frame to cfg_mac, rx_err=0, out_rdy=1 → out_len=64; 64 contiguous bytes identical to input; frm_cnt=1.
REQ-021 Same frame with rx_err=1 on eof, then a good 60-byte frame → only the 60-byte frame is output; drop_cnt=1; RAM space fully reclaimed.
REQ-022 Frame with DA 02:00:00:00:00:99 and cfg_mac different → dropped with cfg_promisc=0; output with cfg_promisc=1; broadcast DA always output.
REQ-023 out_rdy=0, inject 9 good 60-byte frames with LEN_AW=3 → first 8 stored, 9th dropped; after out_rdy=1 exactly 8 frames are emitted in order.
REQ-024 Good frame, then sof without eof after 20 bytes followed by a 30-byte good frame → drop_cnt=1; 30-byte frame delivered intact.
REQ-025 rst asserted mid-frame with a stored frame pending → out_vld=0 next cycle; all counters 0; no frame is output afterwards.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive buffer controller.
package eth_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_DROP = 2'd2
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rstate_e;

    localparam int          ETH_MIN_LEN = 14;
    localparam int          ETH_MAX_LEN = 2047;
    localparam logic [47:0] ETH_BCAST   = 48'hFFFF_FFFF_FFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Byte 0 of the station address sits in the top octet.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_rx_dpram.sv
// Simple dual-port byte RAM: one write port, one read port with a registered output.
module eth_rx_dpram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [1 << ADDR_W];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_ctrl.sv
// Receive frame buffer: stores filtered frames in a byte RAM, queues their lengths and
// replays committed frames on a valid/ready byte stream.
module eth_rx_ctrl
    import eth_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_AW = 3
) (
    input  logic        clk_mac,
    input  logic        rst,
    input  logic        rx_vld,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_err,
    input  logic [7:0]  rx_dat,
    input  logic [47:0] cfg_mac,
    input  logic        cfg_promisc,
    output logic        out_vld,
    output logic [7:0]  out_dat,
    output logic        out_sof,
    output logic        out_eof,
    output logic [10:0] out_len,
    input  logic        out_rdy,
    output logic [15:0] frm_cnt,
    output logic [15:0] drop_cnt
);

    wstate_e           wst_q, wst_d;
    rstate_e           rs_q, rs_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [10:0]       len_q, len_d;
    logic              da_mac_q, da_mac_d, da_bc_q, da_bc_d;
    logic [15:0]       frm_cnt_q, frm_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [LEN_AW:0]   fwp_q, frp_q;
    logic [10:0]       len_mem_q [1 << LEN_AW];
    logic              out_vld_q, out_vld_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic [7:0]        out_dat_q, out_dat_d;
    logic [10:0]       out_len_q, out_len_d, idx_q, idx_d;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [7:0]        ram_rdata;
    logic              push, pop, fifo_full, fifo_empty;
    logic              data_beat, sof_beat, eof_beat, mac_m, bc_m;

    assign data_beat  = rx_vld && !rx_eof;
    assign sof_beat   = data_beat && rx_sof;
    assign eof_beat   = rx_vld && rx_eof;
    assign fifo_empty = (fwp_q == frp_q);
    assign fifo_full  = (fwp_q == {~frp_q[LEN_AW], frp_q[LEN_AW-1:0]});

    eth_rx_dpram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (clk_mac),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (rx_dat),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Outside W_IDLE wr_ptr may be mid-frame; a new frame always restarts from commit_ptr.
    always_comb begin
        wst_d        = wst_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        da_mac_d     = da_mac_q;
        da_bc_d      = da_bc_q;
        frm_cnt_d    = frm_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr_q;
        push         = 1'b0;
        mac_m        = da_mac_q && (rx_dat == mac_byte(cfg_mac, len_q[2:0]));
        bc_m         = da_bc_q && (rx_dat == ETH_BCAST[7:0]);
        if (sof_beat) begin
            if (wst_q != W_IDLE) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
            wr_ptr_d = commit_ptr_q;
            wst_d    = W_DROP;
            if (!fifo_full && (commit_ptr_q + ADDR_W'(1) != rd_ptr_q)) begin
                ram_we    = 1'b1;
                ram_waddr = commit_ptr_q;
                wr_ptr_d  = commit_ptr_q + ADDR_W'(1);
                len_d     = 11'd1;
                da_mac_d  = (rx_dat == mac_byte(cfg_mac, 3'd0));
                da_bc_d   = (rx_dat == ETH_BCAST[7:0]);
                wst_d     = W_DATA;
            end
        end else if (eof_beat) begin
            if (wst_q == W_DATA && !rx_err && len_q >= 11'(ETH_MIN_LEN)) begin
                push         = 1'b1;
                commit_ptr_d = wr_ptr_q;
                frm_cnt_d    = sat_inc(frm_cnt_q);
            end else if (wst_q != W_IDLE) begin
                wr_ptr_d   = commit_ptr_q;
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
            wst_d = W_IDLE;
        end else if (data_beat && wst_q == W_DATA) begin
            // The address verdict is taken on byte 5, once all six octets have been seen.
            if ((wr_ptr_q + ADDR_W'(1) == rd_ptr_q) || (len_q == 11'(ETH_MAX_LEN)) ||
                (len_q == 11'd5 && !cfg_promisc && !mac_m && !bc_m)) begin
                wr_ptr_d = commit_ptr_q;
                wst_d    = W_DROP;
            end else begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                len_d    = len_q + 11'd1;
                if (len_q < 11'd6) begin
                    da_mac_d = mac_m;
                    da_bc_d  = bc_m;
                end
            end
        end
    end

    // The RAM always prefetches the byte after the one on out_dat, so each accept reloads at once.
    always_comb begin
        rs_d      = rs_q;
        rd_ptr_d  = rd_ptr_q;
        ram_raddr = rd_ptr_q;
        pop       = 1'b0;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_sof_d = out_sof_q;
        out_eof_d = out_eof_q;
        out_len_d = out_len_q;
        idx_d     = idx_q;
        case (rs_q)
            R_IDLE: begin
                if (!fifo_empty) begin
                    rs_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_raddr = rd_ptr_q + ADDR_W'(1);
                out_vld_d = 1'b1;
                out_dat_d = ram_rdata;
                out_sof_d = 1'b1;
                out_eof_d = 1'b0;
                out_len_d = len_mem_q[frp_q[LEN_AW-1:0]];
                idx_d     = 11'd0;
                rs_d      = R_DATA;
            end
            R_DATA: begin
                ram_raddr = rd_ptr_q + ADDR_W'(1);
                if (out_vld_q && out_rdy) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    if (out_eof_q) begin
                        out_vld_d = 1'b0;
                        out_sof_d = 1'b0;
                        out_eof_d = 1'b0;
                        pop       = 1'b1;
                        rs_d      = R_IDLE;
                    end else begin
                        ram_raddr = rd_ptr_q + ADDR_W'(2);
                        out_dat_d = ram_rdata;
                        out_sof_d = 1'b0;
                        out_eof_d = (idx_q + 11'd2 == out_len_q);
                        idx_d     = idx_q + 11'd1;
                    end
                end
            end
            default: rs_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_mac) begin
        if (rst) begin
            wst_q        <= W_IDLE;
            rs_q         <= R_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            fwp_q        <= '0;
            frp_q        <= '0;
            frm_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            len_q        <= '0;
            da_mac_q     <= 1'b0;
            da_bc_q      <= 1'b0;
            out_vld_q    <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_dat_q    <= '0;
            out_len_q    <= '0;
            idx_q        <= '0;
        end else begin
            wst_q        <= wst_d;
            rs_q         <= rs_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fwp_q        <= push ? fwp_q + 1'b1 : fwp_q;
            frp_q        <= pop ? frp_q + 1'b1 : frp_q;
            frm_cnt_q    <= frm_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            len_q        <= len_d;
            da_mac_q     <= da_mac_d;
            da_bc_q      <= da_bc_d;
            out_vld_q    <= out_vld_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            out_dat_q    <= out_dat_d;
            out_len_q    <= out_len_d;
            idx_q        <= idx_d;
        end
    end

    always_ff @(posedge clk_mac) begin
        if (push) begin
            len_mem_q[fwp_q[LEN_AW-1:0]] <= len_q;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_dat  = out_dat_q;
    assign out_sof  = out_sof_q;
    assign out_eof  = out_eof_q;
    assign out_len  = out_len_q;
    assign frm_cnt  = frm_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Bench for eth_rx_ctrl: directed and random frames against a frame-level acceptance model.
module tb_eth_rx_ctrl;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_11;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk_mac = 1'b0;
    logic        rst, rx_vld, rx_sof, rx_eof, rx_err;
    logic [7:0]  rx_dat;
    logic [47:0] cfg_mac;
    logic        cfg_promisc;
    logic        out_vld, out_sof, out_eof, out_rdy;
    logic [7:0]  out_dat;
    logic [10:0] out_len;
    logic [15:0] frm_cnt, drop_cnt;

    int   n_cmp, n_bad, n_exp, n_rx, m_frm, m_drop, proto_err, holes, rdy_mode;
    bit   pend_abort, mon_skip;
    logic [7:0] exp_data[$], rx_data[$];
    int   exp_len[$], rx_flen[$], rx_hlen[$];

    // monitor state
    bit          mon_r, in_frm, prev_hold, ps, pe;
    logic [7:0]  pd;
    logic [10:0] pl, cur_h;
    int          cur_n;

    eth_rx_ctrl dut (
        .clk_mac     (clk_mac),
        .rst         (rst),
        .rx_vld      (rx_vld),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_err      (rx_err),
        .rx_dat      (rx_dat),
        .cfg_mac     (cfg_mac),
        .cfg_promisc (cfg_promisc),
        .out_vld     (out_vld),
        .out_dat     (out_dat),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .out_len     (out_len),
        .out_rdy     (out_rdy),
        .frm_cnt     (frm_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk_mac = ~clk_mac;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Consumer: chooses out_rdy for the coming edge, captures accepted bytes, checks the handshake.
    always @(negedge clk_mac) begin
        if (mon_skip) begin
            in_frm    = 1'b0;
            prev_hold = 1'b0;
            cur_n     = 0;
        end else begin
            if (prev_hold && !(out_vld === 1'b1 && out_dat === pd && out_sof === ps &&
                               out_eof === pe && out_len === pl))
                proto_err++;
            if (out_vld && out_sof && out_eof) proto_err++;
            if (in_frm && !out_vld) holes++;
        end
        case (rdy_mode)
            0:       mon_r = 1'b0;
            1:       mon_r = 1'b1;
            default: mon_r = ($urandom_range(0, 1) == 1);
        endcase
        out_rdy = mon_r;
        if (!mon_skip && out_vld && mon_r) begin
            if (out_sof) begin
                in_frm = 1'b1;
                cur_n  = 0;
                cur_h  = out_len;
            end else if (!in_frm) begin
                proto_err++;
            end
            rx_data.push_back(out_dat);
            cur_n++;
            if (out_eof) begin
                rx_flen.push_back(cur_n);
                rx_hlen.push_back(int'(cur_h));
                n_rx++;
                in_frm = 1'b0;
            end
        end
        prev_hold = !mon_skip && out_vld && !mon_r;
        pd = out_dat; ps = out_sof; pe = out_eof; pl = out_len;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference rule: a frame is delivered iff it ends cleanly, is 14..2047 bytes, is addressed to
    // this station (or broadcast, or promiscuous) and the length queue had room when it began.
    task automatic send_frame(input int len, input logic [47:0] da, input bit err,
                              input bit eof_en, input bit gaps);
        int         occ;
        bit         acc;
        logic [7:0] b;
        logic [7:0] q[$];
        occ = n_exp - n_rx;
        if (pend_abort) begin
            m_drop++;
            pend_abort = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(negedge clk_mac);
                    rx_vld = 1'b0;
                end
            end
            b = (i < 6) ? 8'(da >> (40 - 8 * i)) : 8'($urandom);
            @(negedge clk_mac);
            rx_vld = 1'b1; rx_sof = (i == 0); rx_eof = 1'b0; rx_err = 1'b0; rx_dat = b;
            q.push_back(b);
        end
        if (eof_en) begin
            @(negedge clk_mac);
            rx_vld = 1'b1; rx_sof = 1'b0; rx_eof = 1'b1; rx_err = err; rx_dat = 8'h00;
        end
        @(negedge clk_mac);
        rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
        acc = eof_en && !err && len >= 14 && len <= 2047 && occ < 8 &&
              (da == cfg_mac || da == BCAST || cfg_promisc);
        if (acc) begin
            m_frm++;
            n_exp++;
            exp_len.push_back(len);
            foreach (q[j]) exp_data.push_back(q[j]);
        end else if (eof_en) begin
            m_drop++;
        end else begin
            pend_abort = 1'b1;
        end
    endtask

    task automatic drain_and_compare(input int budget);
        int k, L, F, H, mism;
        logic [7:0] a, e;
        k = 0;
        while (n_rx != n_exp && k < budget) begin
            @(negedge clk_mac);
            k++;
        end
        repeat (4) @(negedge clk_mac);
        check("frames_out", n_rx, n_exp);
        while (exp_len.size() > 0 && rx_flen.size() > 0) begin
            L = exp_len.pop_front();
            F = rx_flen.pop_front();
            H = rx_hlen.pop_front();
            check("frame_len", F, L);
            check("out_len", H, L);
            mism = 0;
            for (int i = 0; i < L; i++) begin
                if (rx_data.size() > 0 && exp_data.size() > 0) begin
                    a = rx_data.pop_front();
                    e = exp_data.pop_front();
                    if (a !== e) mism++;
                end else begin
                    mism++;
                end
            end
            check("frame_data", mism, 0);
        end
        exp_len.delete(); rx_flen.delete(); rx_hlen.delete();
        exp_data.delete(); rx_data.delete();
        n_exp = n_rx;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frm_cnt"}, frm_cnt, m_frm);
        check({tag, "_drop_cnt"}, drop_cnt, m_drop);
    endtask

    initial begin
        int k, kind, len;
        logic [47:0] da;
        rst = 1'b1; mon_skip = 1'b1; rdy_mode = 1;
        rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; rx_dat = 8'h00;
        cfg_mac = MAC; cfg_promisc = 1'b0;
        repeat (4) @(negedge clk_mac);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_out_dat", out_dat, 0);
        check("rst_out_len", out_len, 0);
        check("rst_frm_cnt", frm_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        @(negedge clk_mac);
        mon_skip = 1'b0;

        // single 64-byte frame to the station
        send_frame(64, MAC, 1'b0, 1'b1, 1'b0);
        drain_and_compare(400);
        check_counters("good64");

        // errored frame then a good one
        send_frame(64, MAC, 1'b1, 1'b1, 1'b0);
        send_frame(60, MAC, 1'b0, 1'b1, 1'b0);
        drain_and_compare(400);
        check_counters("err_then_good");

        // destination filtering
        send_frame(40, OTHER, 1'b0, 1'b1, 1'b0);
        cfg_promisc = 1'b1;
        send_frame(40, OTHER, 1'b0, 1'b1, 1'b0);
        cfg_promisc = 1'b0;
        send_frame(40, BCAST, 1'b0, 1'b1, 1'b0);
        drain_and_compare(400);
        check_counters("da_filter");

        // length boundaries
        send_frame(13, MAC, 1'b0, 1'b1, 1'b0);
        send_frame(14, MAC, 1'b0, 1'b1, 1'b0);
        send_frame(2048, MAC, 1'b0, 1'b1, 1'b0);
        send_frame(2047, MAC, 1'b0, 1'b1, 1'b0);
        drain_and_compare(5000);
        check_counters("len_bounds");

        // length queue overflow with a stalled consumer
        rdy_mode = 0;
        for (int f = 0; f < 9; f++) send_frame(60, MAC, 1'b0, 1'b1, 1'b0);
        check_counters("fifo_full");
        rdy_mode = 1;
        drain_and_compare(2000);

        // frame aborted by a new start
        send_frame(40, MAC, 1'b0, 1'b1, 1'b0);
        send_frame(20, MAC, 1'b0, 1'b0, 1'b0);
        send_frame(30, MAC, 1'b0, 1'b1, 1'b0);
        drain_and_compare(600);
        check_counters("abort");

        // random traffic with a random consumer
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            k = 0;
            while ((n_exp - n_rx) >= 4 && k < 5000) begin
                @(negedge clk_mac);
                k++;
            end
            check("occ_bound", int'((n_exp - n_rx) < 4), 1);
            kind = $urandom_range(0, 9);
            da = (kind < 6) ? MAC : (kind < 8) ? BCAST : OTHER;
            cfg_promisc = ($urandom_range(0, 3) == 0);
            len = $urandom_range(8, 160);
            send_frame(len, da, ($urandom_range(0, 9) == 0),
                       (f == 39) || ($urandom_range(0, 9) != 0), 1'b1);
        end
        cfg_promisc = 1'b0;
        drain_and_compare(8000);
        check_counters("random");

        // reset with a stored frame pending and a frame in flight
        rdy_mode = 0;
        send_frame(30, MAC, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk_mac);
        check("pre_rst_out_vld", out_vld, 1);
        send_frame(10, MAC, 1'b0, 1'b0, 1'b0);
        mon_skip = 1'b1;
        @(negedge clk_mac);
        rst = 1'b1;
        @(negedge clk_mac);
        check("mid_rst_out_vld", out_vld, 0);
        check("mid_rst_frm_cnt", frm_cnt, 0);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        exp_len.delete(); exp_data.delete();
        n_exp = n_rx; m_frm = 0; m_drop = 0; pend_abort = 1'b0;
        @(negedge clk_mac);
        mon_skip = 1'b0;
        rdy_mode = 1;
        repeat (100) @(negedge clk_mac);
        check("post_rst_frames", n_rx, n_exp);
        check("post_rst_out_vld", out_vld, 0);
        check_counters("post_rst");

        check("proto_violations", proto_err, 0);
        check("frame_holes", holes, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
